// File: rtl/imem_loader.sv
// Boot-time program loader: assembles little-endian words from a byte stream,
// writes them to instruction memory from address 0, then releases the core.
module imem_loader #(
    parameter int IMEM_WORDS = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  byteIn,
    input  logic        byteValid,
    output logic        byteReady,
    output logic        imemWe,
    output logic [31:0] imemAddr,
    output logic [31:0] imemWdata,
    output logic        coreReset,
    output logic [15:0] wordCount,
    output logic        done,
    output logic        error,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_HDR_LO = 3'd1,
        S_HDR_HI = 3'd2,
        S_DATA   = 3'd3,
        S_WRITE  = 3'd4,
        S_RUN    = 3'd5,
        S_ERR    = 3'd6
    } state_t;

    localparam logic [15:0] MAX_N = 16'(IMEM_WORDS);

    state_t      state_q, state_d;
    logic [15:0] n_q, n_d;
    logic [1:0]  byte_idx_q, byte_idx_d;
    logic [31:0] word_q, word_d;
    logic [15:0] word_idx_q, word_idx_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        core_reset_q, core_reset_d;
    logic        done_q, done_d;
    logic        error_q, error_d;

    logic        xfer;
    logic [15:0] hdr_n;
    logic [15:0] word_idx_inc;

    // Handshake: a byte moves on a rising edge only when byteValid && byteReady;
    // byteReady depends on state alone, so it never combinationally follows byteValid.
    assign byteReady    = (state_q == S_HDR_LO) || (state_q == S_HDR_HI) || (state_q == S_DATA);
    assign xfer         = byteValid && byteReady;
    assign hdr_n        = {byteIn, n_q[7:0]};
    assign word_idx_inc = word_idx_q + 16'd1;

    always_comb begin
        state_d      = state_q;
        n_d          = n_q;
        byte_idx_d   = byte_idx_q;
        word_d       = word_q;
        word_idx_d   = word_idx_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        core_reset_d = core_reset_q;
        done_d       = done_q;
        error_d      = error_q;

        case (state_q)
            S_IDLE: state_d = S_HDR_LO;
            S_HDR_LO: begin
                if (xfer) begin
                    n_d     = {n_q[15:8], byteIn};
                    state_d = S_HDR_HI;
                end
            end
            S_HDR_HI: begin
                if (xfer) begin
                    n_d = hdr_n;
                    if (hdr_n == 16'd0) begin
                        state_d      = S_RUN;
                        done_d       = 1'b1;
                        core_reset_d = 1'b0;
                    end else if (hdr_n > MAX_N) begin
                        state_d = S_ERR;
                        error_d = 1'b1;
                    end else begin
                        state_d    = S_DATA;
                        byte_idx_d = 2'd0;
                    end
                end
            end
            S_DATA: begin
                if (xfer) begin
                    case (byte_idx_q)
                        2'd0:    word_d[7:0]   = byteIn;
                        2'd1:    word_d[15:8]  = byteIn;
                        2'd2:    word_d[23:16] = byteIn;
                        default: word_d[31:24] = byteIn;
                    endcase
                    byte_idx_d = byte_idx_q + 2'd1;
                    // Address and data are captured here so they hold steady after the strobe.
                    if (byte_idx_q == 2'd3) begin
                        addr_d  = {14'd0, word_idx_q, 2'b00};
                        wdata_d = word_d;
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                word_idx_d = word_idx_inc;
                if (word_idx_inc == n_q) begin
                    state_d      = S_RUN;
                    done_d       = 1'b1;
                    core_reset_d = 1'b0;
                end else begin
                    state_d    = S_DATA;
                    byte_idx_d = 2'd0;
                end
            end
            S_RUN:   state_d = S_RUN;
            S_ERR:   state_d = S_ERR;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            n_q          <= 16'd0;
            byte_idx_q   <= 2'd0;
            word_q       <= 32'd0;
            word_idx_q   <= 16'd0;
            addr_q       <= 32'd0;
            wdata_q      <= 32'd0;
            core_reset_q <= 1'b1;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            n_q          <= n_d;
            byte_idx_q   <= byte_idx_d;
            word_q       <= word_d;
            word_idx_q   <= word_idx_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            core_reset_q <= core_reset_d;
            done_q       <= done_d;
            error_q      <= error_d;
        end
    end

    // The word index doubles as the written-word count; they always advance together.
    assign imemWe    = (state_q == S_WRITE);
    assign imemAddr  = addr_q;
    assign imemWdata = wdata_q;
    assign coreReset = core_reset_q;
    assign wordCount = word_idx_q;
    assign done      = done_q;
    assign error     = error_q;
    assign dbg_state = state_q;

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader upstream of the single-cycle RISC-V datapath. It receives a program as a byte stream over a valid/ready handshake, assembles little-endian 32-bit instruction words, writes them sequentially into instruction memory from byte address 0, then releases the datapath core from reset. While loading, or after a load error, it holds the core in reset so the PC stays at 0.

## Interface
- IMEM_WORDS, 64: instruction memory capacity in 32-bit words; legal header counts are 0..IMEM_WORDS.
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high; forces every register to its reset value immediately.
- byteIn  in  8  stream byte.
- byteValid  in  1  byteIn is valid this cycle.
- byteReady  out  1  loader accepts a byte this cycle; a transfer occurs on a rising edge with byteValid && byteReady.
- imemWe  out  1  one-cycle instruction-memory write strobe.
- imemAddr  out  32  byte address of the write, {wordIdx, 2'b00}.
- imemWdata  out  32  assembled instruction word.
- coreReset  out  1  drives the datapath reset; high until the load completes.
- wordCount  out  16  number of words written so far.
- done  out  1  load complete; core running.
- error  out  1  header count exceeded IMEM_WORDS.

## Operation
- Stream format: 2-byte header (word count N, low byte first), then N×4 data bytes, least significant byte of each word first.
- States:
  - IDLE: byteReady=0. Always moves to HDR_LO on the next edge.
  - HDR_LO: byteReady=1. On transfer, latch N[7:0] and go to HDR_HI.
  - HDR_HI: byteReady=1. On transfer, latch N[15:8], then:
    - N==0: go to RUN.
    - N>IMEM_WORDS: go to ERR.
    - Otherwise: go to DATA.
  - DATA: byteReady=1. On each transfer, place the byte into lane byteIdx (byteIdx 0 → bits 7:0 … byteIdx 3 → bits 31:24) and increment byteIdx (2 bits). On the transfer with byteIdx==3, go to WRITE.
  - WRITE: byteReady=0, imemWe=1, imemAddr={wordIdx,00}, imemWdata=assembled word, for exactly one cycle. On the edge, wordIdx and wordCount increment. If the new wordCount==N, go to RUN; otherwise go to DATA with byteIdx=0.
  - RUN: byteReady=0, done=1, coreReset=0. Terminal until reset. byteValid is ignored.
  - ERR: byteReady=0, error=1, coreReset=1, no writes. Terminal until reset.
- Arithmetic and widths:
  - wordIdx and wordCount are 16 bits; they never exceed N ≤ IMEM_WORDS, so no wrap.
  - The header compare is unsigned 16-bit.
- imemAddr and imemWdata hold their last values when imemWe=0; the memory ignores them then.
- byteIn while byteValid=0 is don't-care. byteValid asserted while byteReady=0 causes no transfer and no state change.

## Timing
- Reset values:
  - state=IDLE; byteReady=0; imemWe=0; imemAddr=0; imemWdata=0.
  - coreReset=1; wordCount=0; done=0; error=0.
  - Internal N, byteIdx and wordIdx are 0.
- First cycle after reset deassertion: IDLE. byteReady first rises the cycle after that.
- The 4th data-byte transfer edge is followed by one WRITE cycle with imemWe=1. The memory captures on the edge ending that cycle.
- Maximum throughput is 5 cycles per word: 4 transfers + 1 WRITE bubble.
- coreReset and done are registered:
  - For N≥1, they change on the same edge that ends the final WRITE cycle, so the core's first active cycle reads the already-written word 0.
  - For N==0, they change on the edge of the second header byte.
- Reset mid-operation, in any state, aborts immediately. Partially assembled bytes and the header are discarded. coreReset re-asserts asynchronously. Words already written stay in memory, but wordCount returns to 0.

## Test plan
- Two-word load, stream 02 00 93 00 50 00 13 01 A0 00 with byteValid held high:
  - imemWe pulses at addr 0x0 with data 0x00500093, then at addr 0x4 with data 0x00A00113, 5 cycles apart.
  - coreReset falls and done rises at the edge ending the 2nd write; wordCount=2.
- Same stream with random byteValid gaps:
  - Identical write sequence.
  - byteReady=0 in every WRITE cycle.
  - No byte lost or duplicated.
- Header 00 00:
  - No imemWe.
  - done=1 and coreReset=0 one edge after the 2nd header byte.
  - Following bytes are not accepted.
- Header 41 00 (N=65 > 64):
  - error=1 and coreReset stays 1.
  - byteReady=0 thereafter; no imemWe ever.
- Reset asserted after 1 word plus 2 bytes of word 2:
  - All outputs return to reset values within the same cycle.
  - A new stream 01 00 EF BE AD DE writes 0xDEADBEEF at addr 0x0, then done=1.
- Full capacity, N=64 (40 00) with 256 incrementing data bytes:
  - The last write is at addr 0xFC with data 0xFFFEFDFC; wordCount=64; done=1.
  - An extra byte offered afterwards is not accepted.
